bcd_seq_ctrl: RTL
=================

Name: bcd_seq_ctrl

Overview:
Multi-cycle controller that sequences a binary-to-BCD conversion using the double-dabble algorithm, one shift per clock.
- Accepts a binary operand through a valid/ready request handshake.
- Presents the packed BCD result through a valid/ready response handshake.
- Sits between the ROM-based temperature-conversion lookup and the display/digit driver.
- Replaces the wide combinational converter where timing or area matters.

Parameters:
WIDTH, 8, binary input width in bits (WIDTH ≥ 2)
DIGITS, 3, number of BCD output digits; bcd_out is 4*DIGITS bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  requester has an operand on b_in
start_ready  output  1  controller can accept an operand (IDLE only)
b_in  input  WIDTH  binary operand, sampled on the accept edge
done_valid  output  1  bcd_out holds a completed result
done_ready  input  1  consumer accepts the result
bcd_out  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]
busy  output  1  high in SHIFT and DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n low.
- Reset values: state=IDLE, start_ready=1, done_valid=0, busy=0, bcd_out=0, shift register=0, counter=0.
- FSM has three states, defined in the package enum: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: load bin_sr=b_in, clear bcd_sr, set cnt=0, go to SHIFT.
  - With start_valid low, stay in IDLE.
- SHIFT, once per cycle:
  - Every nibble of bcd_sr that is > 4 gets +3 (4-bit wrap; the post-adjust nibble is at most 12).
  - Then shift left: {bcd_sr, bin_sr} <<= 1, with the MSB of bin_sr entering bcd_sr[0].
  - cnt increments each cycle. When cnt==WIDTH-1, go to DONE after that cycle's shift.
  - Order is adjust-before-shift, so no adjust follows the final shift.
- DONE:
  - done_valid=1 and bcd_out=bcd_sr, held stable until done_ready.
  - On done_valid&&done_ready: go to IDLE.
  - bcd_out keeps its last value in IDLE; it changes only on entry to DONE.
- Latency: the accept edge is cycle 0. done_valid rises after exactly WIDTH further edges. Throughput is one conversion per WIDTH+2 cycles at best.
- Counter width is $clog2(WIDTH). cnt wraps to 0 on every load.
- Start handshake:
  - start_ready=0 in SHIFT and DONE.
  - start_valid in those states is ignored. The operand is not queued, and the requester must hold it.
  - Same-cycle done_valid&&done_ready and start_valid: the start is not accepted that cycle, since start_ready is still 0. It is accepted on the next cycle in IDLE.
- done_ready held high: the DONE→IDLE transition occurs on the first DONE cycle.
- Reset mid-operation: the conversion is aborted and all outputs return to reset values with no partial result.
- Undersized DIGITS: if 4*DIGITS is too small for the full range of WIDTH, the upper digits are truncated (see the optional feature).

Optional Feature:
Macro: BCD_SEQ_OVF_EN.
- Defined:
  - Adds an output port ovf (1 bit).
  - A sticky flag is cleared on load. It ORs in bcd_sr[4*DIGITS-1] before each shift, i.e. the bit lost off the top.
  - ovf equals the flag while done_valid=1, and resets to 0.
  - ovf=1 means b_in > 10^DIGITS-1 and bcd_out is invalid.
- Undefined: no ovf port and no flag logic; truncation is silent.

Decomposition:
- Package bcd_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  - localparam BCD_ADJ_THRESH=4'd4 and BCD_ADJ_ADD=4'd3.
  - Function bcd_digits_needed(width), for parameter sanity checks.
- Sub-module bcd_digit_adj: a combinational 4-bit nibble adjuster (nibble>4 ? nibble+3 : nibble). It is instantiated DIGITS times via generate.

Test Plan:
- Full-scale value: b_in=8'd255 accepted at edge 0 → done_valid high after 8 edges with bcd_out=12'h255; busy high throughout.
- Zero and single-digit values:
  - b_in=0 → bcd_out=12'h000.
  - b_in=9 → 12'h009.
  - b_in=100 → 12'h100.
- Back-pressure: done_ready held low 5 cycles after completion of b_in=37 → done_valid and bcd_out=12'h037 stable all 5 cycles; start_valid pulses during this time are ignored (start_ready=0).
- Back-to-back: start_valid held high with b_in=42 then 199, done_ready=1 → results 12'h042 then 12'h199, accepts spaced exactly WIDTH+2 cycles.
- Reset mid-conversion: rst_n low at the 3rd SHIFT cycle of b_in=200 → outputs are immediately at reset values; after release, b_in=7 gives 12'h007.
- BCD_SEQ_OVF_EN defined, DIGITS=2:
  - b_in=99 → bcd_out=8'h99, ovf=0.
  - b_in=150 → ovf=1.
  - The next conversion, b_in=12, gives ovf=0 and 8'h12.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, the double-dabble adjust constants and a sizing helper.
package bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd4;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Decimal digits needed to show the largest unsigned value of 'width' bits.
    function automatic int bcd_digits_needed(input int width);
        longint unsigned v;
        int              n;
        v = (longint'(1) << width) - 1;
        n = 1;
        while (v > 64'd9) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble nibble adjuster: adds 3 to any digit above 4.
// Ports: nib_in (4-bit BCD digit), nib_out (adjusted digit, 4-bit wrap).
module bcd_digit_adj
    import bcd_seq_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (nib_in > BCD_ADJ_THRESH) begin
            nib_out = nib_in + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Multi-cycle double-dabble binary-to-BCD controller, one shift per clock.
// Ports: clk, rst_n (async low), start_valid/start_ready/b_in request,
//        done_valid/done_ready/bcd_out response, busy (SHIFT or DONE),
//        ovf (only when BCD_SEQ_OVF_EN is defined: result truncated).
module bcd_seq_ctrl
    import bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [WIDTH-1:0]      b_in,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BCD_SEQ_OVF_EN
    output logic                  ovf,
`endif
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    bcd_state_t        state_q,   state_d;
    logic [WIDTH-1:0]  bin_sr_q,  bin_sr_d;
    logic [BW-1:0]     bcd_sr_q,  bcd_sr_d;
    logic [BW-1:0]     bcd_out_q, bcd_out_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [BW-1:0]     bcd_adj;

`ifdef BCD_SEQ_OVF_EN
    logic              ovf_flag_q, ovf_flag_d;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_in  (bcd_sr_q[4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        bcd_sr_d  = bcd_sr_q;
        bcd_out_d = bcd_out_q;
        cnt_d     = cnt_q;
`ifdef BCD_SEQ_OVF_EN
        ovf_flag_d = ovf_flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    bin_sr_d = b_in;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
`ifdef BCD_SEQ_OVF_EN
                    ovf_flag_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // Adjust first, then shift the binary MSB into digit 0.
                bcd_sr_d = {bcd_adj[BW-2:0], bin_sr_q[WIDTH-1]};
                bin_sr_d = {bin_sr_q[WIDTH-2:0], 1'b0};
                cnt_d    = cnt_q + 1'b1;
`ifdef BCD_SEQ_OVF_EN
                // Bit falling off the top digit means the value did not fit.
                ovf_flag_d = ovf_flag_q | bcd_adj[BW-1];
`endif
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    bcd_out_d = {bcd_adj[BW-2:0], bin_sr_q[WIDTH-1]};
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_sr_q  <= '0;
            bcd_sr_q  <= '0;
            bcd_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_sr_q  <= bin_sr_d;
            bcd_sr_q  <= bcd_sr_d;
            bcd_out_q <= bcd_out_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef BCD_SEQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag_q <= 1'b0;
        end else begin
            ovf_flag_q <= ovf_flag_d;
        end
    end

    assign ovf = ovf_flag_q & (state_q == DONE);
`endif

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign bcd_out     = bcd_out_q;

endmodule
